// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage holding the PC, selecting next PC and loading the IF/ID register with stall/flush.
module fetch_stage #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int IMEM_BYTES = 400
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Fetch_Stall,
  input  logic             Fetch_BranchTaken,
  input  logic [WIDTH-1:0] Fetch_BranchTarget,
  input  logic             Fetch_Jump,
  input  logic [WIDTH-1:0] Fetch_JumpTarget,
  input  logic [WIDTH-1:0] Fetch_Instr,
  output logic [WIDTH-1:0] Fetch_PC,
  output logic [WIDTH-1:0] Fetch_InstrD,
  output logic [WIDTH-1:0] Fetch_PCPlus4D,
  output logic             Fetch_ValidD,
  output logic [31:0]      Fetch_Count,
  output logic             Fetch_Overrun
);
  logic [WIDTH-1:0] pc_q, pc_d, instr_q, instr_d, pcp4_q, pcp4_d, pc_plus4;
  logic [31:0] cnt_q, cnt_d;
  logic valid_q, valid_d, ovr_q, ovr_d, redirect, deliver;
  always_comb begin
    pc_plus4 = pc_q + WIDTH'(4);
    redirect = Fetch_Jump | Fetch_BranchTaken;
    deliver  = !Fetch_Stall && !redirect;
    // targets are word-aligned by dropping the two low bits
    pc_d     = Fetch_Stall ? pc_q :
               Fetch_Jump ? (Fetch_JumpTarget & ~WIDTH'(3)) :
               Fetch_BranchTaken ? (Fetch_BranchTarget & ~WIDTH'(3)) : pc_plus4;
    instr_d  = Fetch_Stall ? instr_q : redirect ? '0 : Fetch_Instr;
    pcp4_d   = Fetch_Stall ? pcp4_q : redirect ? '0 : pc_plus4;
    valid_d  = Fetch_Stall ? valid_q : !redirect;
    cnt_d    = deliver ? cnt_q + 32'd1 : cnt_q;
    ovr_d    = ovr_q | (deliver && pc_q >= WIDTH'(IMEM_BYTES));
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pcp4_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end
  assign Fetch_PC       = pc_q;
  assign Fetch_InstrD   = instr_q;
  assign Fetch_PCPlus4D = pcp4_q;
  assign Fetch_ValidD   = valid_q;
  assign Fetch_Count    = cnt_q;
  assign Fetch_Overrun  = ovr_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and random stimulus against a reference fetch model with a 400-byte instruction memory.
module tb_fetch_stage;
  logic clk = 0, rst = 0;
  logic stall = 0, br = 0, jmp = 0;
  logic [31:0] bt = 0, jt = 0, instr;
  logic [31:0] pc, instr_d, pcp4_d, cnt;
  logic valid_d, ovr;
  logic [31:0] mem [0:99];
  int vectors = 0, miscompares = 0;
  logic [31:0] m_pc, m_instr, m_p4, m_cnt;
  logic m_valid, m_ovr;

  fetch_stage dut (
    .CLK(clk), .RST(rst), .Fetch_Stall(stall), .Fetch_BranchTaken(br),
    .Fetch_BranchTarget(bt), .Fetch_Jump(jmp), .Fetch_JumpTarget(jt),
    .Fetch_Instr(instr), .Fetch_PC(pc), .Fetch_InstrD(instr_d),
    .Fetch_PCPlus4D(pcp4_d), .Fetch_ValidD(valid_d), .Fetch_Count(cnt),
    .Fetch_Overrun(ovr)
  );

  always #5 clk = ~clk;
  assign instr = (pc < 32'd400) ? mem[pc[8:2]] : 32'd0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a < 400) ? mem[a / 4] : 32'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("pc", pc, m_pc);
    check("instr_d", instr_d, m_instr);
    check("pcp4_d", pcp4_d, m_p4);
    check("valid_d", {31'd0, valid_d}, {31'd0, m_valid});
    check("count", cnt, m_cnt);
    check("overrun", {31'd0, ovr}, {31'd0, m_ovr});
  endtask

  task automatic model_reset();
    m_pc = 0; m_instr = 0; m_p4 = 0; m_valid = 0; m_cnt = 0; m_ovr = 0;
  endtask

  task automatic step(input logic s, input logic b, input logic [31:0] btg,
                      input logic j, input logic [31:0] jtg);
    stall = s; br = b; bt = btg; jmp = j; jt = jtg;
    @(posedge clk);
    if (!s) begin
      if (j || b) begin
        m_instr = 0; m_p4 = 0; m_valid = 0;
      end else begin
        m_instr = mem_word(m_pc); m_p4 = m_pc + 4; m_valid = 1; m_cnt++;
        if (m_pc >= 400) m_ovr = 1;
      end
      m_pc = j ? {jtg[31:2], 2'b00} : b ? {btg[31:2], 2'b00} : m_pc + 4;
    end
    #1 check_all();
  endtask

  task automatic async_reset();
    #2 rst = 1;
    #1 model_reset();
    check_all();
    #1 rst = 0;
  endtask

  task automatic free_step();
    step(0, 0, 0, 0, 0);
  endtask

  initial begin
    foreach (mem[i]) mem[i] = $urandom;
    mem[0] = 32'h20080005; mem[1] = 32'h20090003; mem[2] = 32'h01095020;
    model_reset();
    @(posedge clk); #1;
    async_reset();
    free_step(); free_step(); free_step();
    check("third_instr", instr_d, 32'h01095020);
    async_reset();
    free_step(); free_step();
    step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
    free_step();
    check("after_stall_instr", instr_d, mem[2]);
    free_step();
    step(0, 1, 32'h41, 0, 0);
    check("branch_pc", pc, 32'h40);
    free_step();
    check("branch_p4", pcp4_d, 32'h44);
    step(0, 1, 32'h40, 1, 32'h80);
    check("jump_wins", pc, 32'h80);
    free_step();
    step(1, 1, 32'h40, 1, 32'h80);
    step(0, 0, 0, 1, 396);
    free_step(); free_step();
    check("overrun_set", {31'd0, ovr}, 32'd1);
    step(0, 0, 0, 1, 0);
    free_step();
    step(0, 0, 0, 1, 32'hFFFF_FFFC);
    free_step();
    check("pc_wrap", pc, 32'd0);
    step(0, 0, 0, 1, 32'h40);
    step(1, 0, 0, 0, 0);
    stall = 1;
    async_reset();
    free_step();
    for (int i = 0; i < 400; i++) begin
      logic s, b, j;
      logic [31:0] bta, jta;
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 7) == 0);
      j = ($urandom_range(0, 9) == 0);
      bta = $urandom_range(0, 420);
      jta = ($urandom_range(0, 19) == 0) ? $urandom : $urandom_range(0, 420);
      step(s, b, bta, j, jta);
      if ($urandom_range(0, 99) == 0) async_reset();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage 32-bit MIPS pipeline, directly upstream of the combinational instruction memory.
- Holds the program counter and drives it as the instruction-memory address.
- Computes the next PC from three sources: sequential, taken branch and jump.
- Captures the returned word in the IF/ID pipeline register, with stall, redirect flush, a bubble valid bit, a fetch counter and a sticky overrun flag.

Parameters:
- WIDTH, 32, datapath/PC/instruction width in bits.
- RESET_PC, 0, PC value loaded on reset.
- IMEM_BYTES, 400, byte size of instruction memory; PC >= IMEM_BYTES is out of range.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous active-high reset.
- Fetch_Stall  input  1  hazard-unit stall; freezes PC and IF/ID.
- Fetch_BranchTaken  input  1  decode-resolved taken branch.
- Fetch_BranchTarget  input  WIDTH  branch target byte address.
- Fetch_Jump  input  1  decode-stage jump.
- Fetch_JumpTarget  input  WIDTH  jump target byte address.
- Fetch_Instr  input  WIDTH  word returned by instruction memory for Fetch_PC (same cycle).
- Fetch_PC  output  WIDTH  current PC, instruction-memory address.
- Fetch_InstrD  output  WIDTH  IF/ID instruction.
- Fetch_PCPlus4D  output  WIDTH  IF/ID PC+4.
- Fetch_ValidD  output  1  IF/ID holds a real instruction (0 = bubble).
- Fetch_Count  output  32  instructions delivered to decode, wraps at 2^32.
- Fetch_Overrun  output  1  sticky: an out-of-range PC was fetched.

Behaviour:
- Reset: asynchronous, active-high, effective immediately and regardless of clock.
  - Fetch_PC = RESET_PC.
  - Fetch_InstrD = 0, Fetch_PCPlus4D = 0, Fetch_ValidD = 0.
  - Fetch_Count = 0, Fetch_Overrun = 0.
  - Reset mid-stall or mid-redirect discards all state; the first post-reset edge fetches RESET_PC.
- PCPlus4 = Fetch_PC + 4, modulo 2^WIDTH; wraps from 0xFFFFFFFC to 0.
- Targets: bits [1:0] of both target inputs are forced to 0 before loading (word alignment).
- Next-PC priority per rising edge, highest first:
  1. Fetch_Stall=1: PC holds. IF/ID, Fetch_Count and Fetch_Overrun all hold. Redirect inputs are ignored; the hazard unit re-presents them after the stall.
  2. Fetch_Jump=1: PC <= JumpTarget.
  3. Fetch_BranchTaken=1: PC <= BranchTarget.
  4. Otherwise: PC <= PCPlus4.
  - If Jump and BranchTaken are both asserted, Jump wins.
- IF/ID register, only when not stalled:
  - Redirect (Jump or BranchTaken): flush. InstrD <= 0, PCPlus4D <= 0, ValidD <= 0. The wrong-path word at Fetch_PC is discarded.
  - Otherwise: InstrD <= Fetch_Instr, PCPlus4D <= PCPlus4, ValidD <= 1.
- Latency: the instruction at address A appears on Fetch_InstrD one edge after Fetch_PC = A. The redirect penalty is exactly one bubble cycle.
- Fetch_Count increments by 1 on every edge where IF/ID loads with ValidD <= 1.
- Fetch_Overrun sets on an unstalled, non-redirect edge where Fetch_PC >= IMEM_BYTES. It is cleared only by RST.
  - The instruction is still delivered: memory returns 0 out of range, and 0 is a NOP.
- No combinational path from any input to any output except Fetch_PC. Fetch_PC is a direct register output.

Test Plan:
- RST pulsed asynchronously between edges -> Fetch_PC=0, ValidD=0, Count=0 immediately. Three free edges with memory words 0x20080005, 0x20090003, 0x01095020 -> Fetch_PC = 4, 8, 12. Fetch_InstrD = the three words in order, PCPlus4D = 4, 8, 12, Count = 3.
- Fetch_Stall held for 2 edges at PC=8 -> PC stays 8, InstrD/PCPlus4D/Count unchanged. Release -> PC=12 and InstrD = word at 8.
- Fetch_BranchTaken=1, target 0x00000041 at PC=16 -> next edge PC=0x40, ValidD=0, InstrD=0, Count unchanged. Following edge InstrD = word at 0x40, PCPlus4D=0x44.
- Jump=1 (target 0x80) and BranchTaken=1 (target 0x40) together -> PC=0x80, one bubble. Same request with Fetch_Stall=1 -> PC holds and no flush occurs.
- IMEM_BYTES=400, jump to 396 -> PC=396, then 400. Fetch at 400 -> Fetch_Overrun=1 and InstrD=0, ValidD=1. Flag stays 1 after later jump to 0, until RST.
- RST asserted while Fetch_Stall=1 and PC=0x40 -> PC=RESET_PC, all IF/ID and status outputs cleared immediately.
